// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default widths, the hard-wired zero register and port slice helpers.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

  // LSB of read port k within the flattened index bus
  function automatic int rd_addr_lsb(input int k, input int addr_width);
    return k * addr_width;
  endfunction

  // LSB of read port k within the flattened data bus
  function automatic int rd_data_lsb(input int k, input int data_width);
    return k * data_width;
  endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// One busy bit per architectural register; flush beats claim beats write.
// Per-port lookup hides a busy bit that is being cleared this cycle when bypassing.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_reg_write,
  input  logic [ADDR_WIDTH-1:0]                i_write_register,
  input  logic                                 i_claim,
  input  logic [ADDR_WIDTH-1:0]                i_claim_register,
  input  logic                                 i_flush,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  rd_idx,
  output logic [NUM_READ-1:0]                  o_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RZ = ADDR_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0] busy;

  // The claim assignment comes last so it overrides a same-cycle write clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (i_flush) begin
      busy <= '0;
    end else begin
      if (i_reg_write && i_write_register != RZ) busy[i_write_register] <= 1'b0;
      if (i_claim && i_claim_register != RZ)     busy[i_claim_register] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic clr_now;
    assign clr_now  = (BYPASS != 0) && i_reg_write && (i_write_register == rd_idx[k]);
    assign o_busy[k] = (rd_idx[k] != RZ) && busy[rd_idx[k]] && !clr_now;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with optional same-cycle write bypass and a busy
// scoreboard for ID-stage hazard detection. Register 0 is hard-wired to zero.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_reg_write,
  input  logic [ADDR_WIDTH-1:0]          i_write_register,
  input  logic [DATA_WIDTH-1:0]          i_write_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] i_read_register,
  output logic [NUM_READ*DATA_WIDTH-1:0] o_read_data,
  output logic [NUM_READ-1:0]            o_busy,
  input  logic                           i_claim,
  input  logic [ADDR_WIDTH-1:0]          i_claim_register,
  input  logic                           i_flush
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RZ = ADDR_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem;
  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] rd_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (i_reg_write && i_write_register != RZ) begin
      mem[i_write_register] <= i_write_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic hit;
    assign rd_idx[k] = i_read_register[rd_addr_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
    // Bypass is gated by reset so reads stay zero while reset is held.
    assign hit = (BYPASS != 0) && reset && i_reg_write && (i_write_register == rd_idx[k]);
    assign o_read_data[rd_data_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      (rd_idx[k] == RZ) ? '0 : (hit ? i_write_data : mem[rd_idx[k]]);
  end

  busy_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .BYPASS     (BYPASS)
  ) u_busy (
    .clk              (clk),
    .reset            (reset),
    .i_reg_write      (i_reg_write),
    .i_write_register (i_write_register),
    .i_claim          (i_claim),
    .i_claim_register (i_claim_register),
    .i_flush          (i_flush),
    .rd_idx           (rd_idx),
    .o_busy           (o_busy)
  );

endmodule
